wb_commit_queue: RTL and testbench

//   Dual-issue writeback/commit buffer: the write-side producer for the dual-write-port register file.

---
 rtl/wb_commit_queue.sv | 174 +++++++++++++++++
 tb/tb_wb_commit_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: dual-issue writeback/commit buffer feeding a two-write-port
// register file. Results are queued in program order and issued up to two per
// cycle from registered outputs; two same-address writes in one issue cycle
// are merged so only the younger write reaches the register file.
// Optional feature: define WB_COMMIT_CNT_EN to add the commit_cnt output.
module wb_commit_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     commit_stall,
  input  logic                     in_valid_1,
  input  logic [ADDR_W-1:0]        in_pc_1,
  input  logic                     in_we_1,
  input  logic [REG_AW-1:0]        in_waddr_1,
  input  logic [DATA_W-1:0]        in_wdata_1,
  input  logic                     in_valid_2,
  input  logic [ADDR_W-1:0]        in_pc_2,
  input  logic                     in_we_2,
  input  logic [REG_AW-1:0]        in_waddr_2,
  input  logic [DATA_W-1:0]        in_wdata_2,
  output logic                     in_ready,
  output logic                     we_1,
  output logic [ADDR_W-1:0]        pc_o_1,
  output logic [REG_AW-1:0]        waddr_1,
  output logic [DATA_W-1:0]        wdata_1,
  output logic                     we_2,
  output logic [ADDR_W-1:0]        pc_o_2,
  output logic [REG_AW-1:0]        waddr_2,
  output logic [DATA_W-1:0]        wdata_2,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_COMMIT_CNT_EN
  ,
  output logic [31:0]              commit_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          r_we_1;
  logic          r_we_2;
  ent_t          r_out_1;
  ent_t          r_out_2;

  logic          w_acc_1;
  logic          w_acc_2;
  ent_t          w_in_1;
  ent_t          w_in_2;
  ent_t          w_new_0;
  ent_t          w_new_1;
  logic [1:0]    w_nenq;
  logic [CW-1:0] w_avail;
  logic [1:0]    w_ndeq;
  ent_t          w_pop_0;
  ent_t          w_pop_1;

  assign in_ready = (r_count <= CW'(DEPTH - 2));

  assign w_acc_1 = in_valid_1 && in_ready && in_we_1 && (in_waddr_1 != '0) && !flush && !rst;
  assign w_acc_2 = in_valid_2 && in_ready && in_we_2 && (in_waddr_2 != '0) && !flush && !rst;
  assign w_in_1  = '{pc: in_pc_1, waddr: in_waddr_1, wdata: in_wdata_1};
  assign w_in_2  = '{pc: in_pc_2, waddr: in_waddr_2, wdata: in_wdata_2};

  // Compact accepted slots (oldest first) and pick the two oldest entries,
  // reading past the stored entries into this cycle's arrivals so an empty
  // queue issues its input on the very next cycle.
  always_comb begin
    w_new_0 = w_acc_1 ? w_in_1 : w_in_2;
    w_new_1 = w_in_2;
    w_nenq  = {1'b0, w_acc_1} + {1'b0, w_acc_2};
    w_avail = r_count + CW'(w_nenq);
    if (commit_stall || flush)
      w_ndeq = 2'd0;
    else if (w_avail >= CW'(2))
      w_ndeq = 2'd2;
    else
      w_ndeq = w_avail[1:0];
    w_pop_0 = (r_count != '0) ? r_mem[r_rd] : w_new_0;
    if (r_count >= CW'(2))
      w_pop_1 = r_mem[r_rd + PW'(1)];
    else if (r_count == CW'(1))
      w_pop_1 = w_new_0;
    else
      w_pop_1 = w_new_1;
  end

  // Arrivals are always written to storage; bypassed ones are consumed by
  // advancing the read pointer past them in the same cycle.
  always_ff @(posedge clk) begin
    if (w_nenq != 2'd0)
      r_mem[r_wr] <= w_new_0;
    if (w_nenq == 2'd2)
      r_mem[r_wr + PW'(1)] <= w_new_1;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + PW'(w_nenq);
      r_rd    <= r_rd + PW'(w_ndeq);
      r_count <= r_count + CW'(w_nenq) - CW'(w_ndeq);
    end
  end

  // Registered write ports, merging same-address pairs into the younger write.
  always_ff @(posedge clk) begin
    if (rst || flush || w_ndeq == 2'd0) begin
      r_we_1  <= 1'b0;
      r_we_2  <= 1'b0;
      r_out_1 <= '0;
      r_out_2 <= '0;
    end else if (w_ndeq == 2'd1) begin
      r_we_1  <= 1'b1;
      r_we_2  <= 1'b0;
      r_out_1 <= w_pop_0;
      r_out_2 <= '0;
    end else if (w_pop_0.waddr == w_pop_1.waddr) begin
      r_we_1  <= 1'b0;
      r_we_2  <= 1'b1;
      r_out_1 <= '0;
      r_out_2 <= w_pop_1;
    end else begin
      r_we_1  <= 1'b1;
      r_we_2  <= 1'b1;
      r_out_1 <= w_pop_0;
      r_out_2 <= w_pop_1;
    end
  end

  assign we_1    = r_we_1;
  assign pc_o_1  = r_out_1.pc;
  assign waddr_1 = r_out_1.waddr;
  assign wdata_1 = r_out_1.wdata;
  assign we_2    = r_we_2;
  assign pc_o_2  = r_out_2.pc;
  assign waddr_2 = r_out_2.waddr;
  assign wdata_2 = r_out_2.wdata;
  assign count   = r_count;

`ifdef WB_COMMIT_CNT_EN
  logic [31:0] r_commit_cnt;

  // Count writes actually presented to the register file; survives flush.
  always_ff @(posedge clk) begin
    if (rst)
      r_commit_cnt <= '0;
    else
      r_commit_cnt <= r_commit_cnt + 32'(r_we_1) + 32'(r_we_2);
  end

  assign commit_cnt = r_commit_cnt;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_wb_commit_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic v1, we1, v2, we2;
  logic [ADDR_W-1:0] pc1, pc2;
  logic [REG_AW-1:0] a1, a2;
  logic [DATA_W-1:0] d1, d2;
  logic in_ready, o_we1, o_we2;
  logic [ADDR_W-1:0] o_pc1, o_pc2;
  logic [REG_AW-1:0] o_a1, o_a2;
  logic [DATA_W-1:0] o_d1, o_d2;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_COMMIT_CNT_EN
  logic [31:0] commit_cnt;
`endif

  wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .commit_stall(stall),
    .in_valid_1(v1), .in_pc_1(pc1), .in_we_1(we1), .in_waddr_1(a1), .in_wdata_1(d1),
    .in_valid_2(v2), .in_pc_2(pc2), .in_we_2(we2), .in_waddr_2(a2), .in_wdata_2(d2),
    .in_ready(in_ready),
    .we_1(o_we1), .pc_o_1(o_pc1), .waddr_1(o_a1), .wdata_1(o_d1),
    .we_2(o_we2), .pc_o_2(o_pc2), .waddr_2(o_a2), .wdata_2(o_d2),
    .count(count)
`ifdef WB_COMMIT_CNT_EN
    , .commit_cnt(commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [REG_AW-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_valid = 0;
  bit   m_we1, m_we2;
  ent_t m_p1, m_p2;
  longint m_cnt;

  always @(posedge clk) begin
    ent_t e0, e1;
    int n;
    if (rst) m_cnt = 0;
    else     m_cnt = (m_cnt + m_we1 + m_we2) % 64'h1_0000_0000;
    if (rst || flush) begin
      q.delete();
      m_we1 = 0; m_we2 = 0;
      m_valid = m_valid | rst;
    end else begin
      if (q.size() <= DEPTH - 2) begin
        if (v1 && we1 && a1 != 0) q.push_back('{pc1, a1, d1});
        if (v2 && we2 && a2 != 0) q.push_back('{pc2, a2, d2});
      end
      m_we1 = 0; m_we2 = 0;
      if (!stall) begin
        n = (q.size() < 2) ? q.size() : 2;
        if (n == 1) begin
          m_p1 = q.pop_front(); m_we1 = 1;
        end else if (n == 2) begin
          e0 = q.pop_front(); e1 = q.pop_front();
          if (e0.a == e1.a) begin
            m_we2 = 1; m_p2 = e1;
          end else begin
            m_we1 = 1; m_p1 = e0; m_we2 = 1; m_p2 = e1;
          end
        end
      end
    end
  end

  // Single compare process: DUT outputs vs model every cycle after reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count", count, q.size());
      chk("in_ready", in_ready, q.size() <= DEPTH - 2);
      chk("we_1", o_we1, m_we1);
      chk("we_2", o_we2, m_we2);
      if (m_we1 && o_we1) begin
        chk("waddr_1", o_a1, m_p1.a); chk("wdata_1", o_d1, m_p1.d); chk("pc_o_1", o_pc1, m_p1.pc);
      end
      if (m_we2 && o_we2) begin
        chk("waddr_2", o_a2, m_p2.a); chk("wdata_2", o_d2, m_p2.d); chk("pc_o_2", o_pc2, m_p2.pc);
      end
`ifdef WB_COMMIT_CNT_EN
      chk("commit_cnt", commit_cnt, m_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    v1 = 0; we1 = 0; a1 = 0; d1 = 0; pc1 = 0;
    v2 = 0; we2 = 0; a2 = 0; d2 = 0; pc2 = 0;
  endtask

  task automatic pair(input logic [REG_AW-1:0] ra, input logic [DATA_W-1:0] da,
                      input logic [REG_AW-1:0] rb, input logic [DATA_W-1:0] db);
    v1 = 1; we1 = 1; a1 = ra; d1 = da; pc1 = 32'h1c00_0000 + 32'(ra) * 8;
    v2 = 1; we2 = 1; a2 = rb; d2 = db; pc2 = 32'h1c00_0004 + 32'(ra) * 8;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    longint c0;
    rst = 1; flush = 0; stall = 0; idle();
    tick(); tick();
    // reset state
    chk("rst_we_1", o_we1, 0); chk("rst_we_2", o_we2, 0);
    chk("rst_count", count, 0); chk("rst_ready", in_ready, 1);
    rst = 0;

    // two distinct writes issue on the next cycle
    v1 = 1; we1 = 1; a1 = 3; d1 = 32'h11; pc1 = 32'h1c00_0000;
    v2 = 1; we2 = 1; a2 = 4; d2 = 32'h22; pc2 = 32'h1c00_0004;
    tick(); idle();
    chk("t2_we_1", o_we1, 1); chk("t2_waddr_1", o_a1, 3); chk("t2_wdata_1", o_d1, 32'h11);
    chk("t2_pc_1", o_pc1, 32'h1c00_0000);
    chk("t2_we_2", o_we2, 1); chk("t2_waddr_2", o_a2, 4); chk("t2_wdata_2", o_d2, 32'h22);
    chk("t2_count", count, 0);

    // same-address pair merges into the younger write
    pair(5, 32'hA, 5, 32'hB);
    tick(); idle();
    chk("t3_we_1", o_we1, 0); chk("t3_we_2", o_we2, 1);
    chk("t3_waddr_2", o_a2, 5); chk("t3_wdata_2", o_d2, 32'hB);
`ifdef WB_COMMIT_CNT_EN
    c0 = commit_cnt;
    tick();
    chk("t3_commit_cnt", commit_cnt, c0 + 1);
`else
    c0 = 0;
    tick();
`endif

    // fill under stall, reject when full, then drain in order
    stall = 1; pair(1, 32'h101, 2, 32'h102);
    tick(); chk("t4_count2", count, 2); chk("t4_ready2", in_ready, 1);
    pair(3, 32'h103, 4, 32'h104);
    tick(); chk("t4_count4", count, 4); chk("t4_ready4", in_ready, 0);
    chk("t4_stall_we", o_we1 | o_we2, 0);
    pair(6, 32'h106, 7, 32'h107);
    tick(); chk("t4_rejected", count, 4);
    idle(); stall = 0;
    tick(); chk("t4_a1", o_a1, 1); chk("t4_a2", o_a2, 2); chk("t4_cnt_mid", count, 2);
    tick(); chk("t4_b1", o_a1, 3); chk("t4_b2", o_a2, 4); chk("t4_ready_end", in_ready, 1);
    chk("t4_cnt_end", count, 0);

    // r0 and non-writing slots are dropped
    v1 = 1; we1 = 1; a1 = 0; d1 = 32'h55; v2 = 1; we2 = 0; a2 = 9; d2 = 32'h66;
    tick(); idle();
    chk("t5_count", count, 0); chk("t5_we", o_we1 | o_we2, 0);

    // flush discards queued entries
    stall = 1; pair(1, 32'h201, 2, 32'h202);
    tick(); v2 = 0; a1 = 7;
    tick(); idle(); chk("t6_count3", count, 3);
`ifdef WB_COMMIT_CNT_EN
    c0 = commit_cnt;
`endif
    flush = 1; pair(8, 32'h1, 9, 32'h2);
    tick(); flush = 0; idle(); stall = 0;
    chk("t6_count0", count, 0);
    tick(); tick();
    chk("t6_we", o_we1 | o_we2, 0);
`ifdef WB_COMMIT_CNT_EN
    chk("t6_commit_cnt", commit_cnt, c0);
`endif

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      v1 = $urandom_range(0, 1); we1 = ($urandom_range(0, 3) != 0);
      a1 = REG_AW'($urandom_range(0, 7)); d1 = $urandom; pc1 = $urandom;
      v2 = $urandom_range(0, 1); we2 = ($urandom_range(0, 3) != 0);
      a2 = REG_AW'($urandom_range(0, 7)); d2 = $urandom; pc2 = $urandom;
      tick();
    end
    rst = 0; flush = 0; stall = 0; idle();
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
